// File: rtl/axis_layer_connector.sv
// rtl/axis_layer_connector.sv - snapshots N_CH neuron results on layer-done and streams them as one AXI4-Stream frame
// Optional frame header beat enabled by defining AXIS_LAYER_CONN_HDR_EN.
module axis_layer_connector #(
    parameter int N_CH   = 18,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_done,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic                     busy,
    output logic                     overrun,
    output logic [CNT_W-1:0]         frame_cnt
);

`ifdef AXIS_LAYER_CONN_HDR_EN
    localparam int HDR_BEATS = 1;
`else
    localparam int HDR_BEATS = 0;
`endif
    localparam int N_BEATS = N_CH + HDR_BEATS;
    localparam int IDX_W   = $clog2(N_BEATS);
    localparam int BUF_AW  = (N_CH > 1) ? $clog2(N_CH) : 1;

    if (N_CH < 2 || N_CH > 256) begin : g_nch_check
        $error("axis_layer_connector: N_CH must be in 2..256");
    end
`ifdef AXIS_LAYER_CONN_HDR_EN
    if (DATA_W < 32) begin : g_hdr_width_check
        $error("axis_layer_connector: header needs DATA_W >= 32");
    end
`endif

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 done_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]    m_tdata_q, m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 m_tlast_q, m_tlast_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]    shadow_q [N_CH];

    logic                 all_done;
    logic                 done_rise;
    logic                 in_stream;
    logic                 hs;
    logic                 last_beat;
    logic                 final_hs;
    logic                 start;
    logic [IDX_W-1:0]     idx_inc;
    logic [IDX_W-1:0]     rd_idx;
    logic [DATA_W-1:0]    next_data;
    logic [DATA_W-1:0]    first_beat;

    assign all_done  = &ch_done;
    assign done_rise = all_done & ~done_q;
    assign in_stream = (state_q == STREAM);
    assign hs        = m_tvalid_q & m_tready;
    assign last_beat = (idx_q == IDX_W'(N_BEATS - 1));
    assign final_hs  = in_stream & hs & last_beat;
    // A rise landing on the final handshake starts the next frame with no bubble.
    assign start     = done_rise & (~in_stream | final_hs);
    assign idx_inc   = idx_q + IDX_W'(1);

`ifdef AXIS_LAYER_CONN_HDR_EN
    // Beat b (b >= 1) carries channel b-1, so the beat after idx reads channel idx.
    assign rd_idx     = last_beat ? '0 : idx_q;
    assign first_beat = DATA_W'({16'(frame_cnt_d), 16'(N_CH)});
`else
    assign rd_idx     = last_beat ? '0 : idx_inc;
    assign first_beat = ch_data[DATA_W-1:0];
`endif
    assign next_data = shadow_q[BUF_AW'(rd_idx)];

    always_ff @(posedge clk or negedge resetn) begin : state_reg
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state_comb
        state_d = state_q;
        case (state_q)
            IDLE:    if (done_rise) state_d = STREAM;
            STREAM:  if (final_hs && !done_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : output_comb
        idx_d       = idx_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        busy_d      = busy_q;
        frame_cnt_d = final_hs ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
        overrun_d   = overrun_q | (done_rise & in_stream & ~final_hs);
        if (start) begin
            idx_d      = '0;
            m_tdata_d  = first_beat;
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b0;
            busy_d     = 1'b1;
        end else if (final_hs) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            busy_d     = 1'b0;
        end else if (in_stream && hs) begin
            idx_d     = idx_inc;
            m_tdata_d = next_data;
            m_tlast_d = (idx_inc == IDX_W'(N_BEATS - 1));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin : out_reg
        if (!resetn) begin
            done_q      <= 1'b0;
            idx_q       <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            done_q      <= all_done;
            idx_q       <= idx_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Snapshot storage carries no reset; it is only read after a capture.
    always_ff @(posedge clk) begin : shadow_reg
        if (start) begin
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_axis_layer_connector.sv
// tb/tb_axis_layer_connector.sv - randomized self-checking bench for axis_layer_connector against a frame-queue model
module tb_axis_layer_connector;
    localparam int N = 18;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [N*W-1:0]   ch_data = '0;
    logic [N-1:0]     ch_done = '0;
    logic             m_tready = 1'b0;

    logic [W-1:0]     m_tdata, m_tdata2;
    logic             m_tvalid, m_tvalid2;
    logic             m_tlast, m_tlast2;
    logic             busy, busy2;
    logic             overrun, overrun2;
    logic [15:0]      frame_cnt;
    logic [1:0]       frame_cnt2;

    axis_layer_connector #(.N_CH(N), .DATA_W(W), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .ch_data(ch_data), .ch_done(ch_done),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    axis_layer_connector #(.N_CH(N), .DATA_W(W), .CNT_W(2)) dut_small (
        .clk(clk), .resetn(resetn), .ch_data(ch_data), .ch_done(ch_done),
        .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tlast(m_tlast2), .m_tready(m_tready),
        .busy(busy2), .overrun(overrun2), .frame_cnt(frame_cnt2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_beats [$];
    logic [31:0]   exp_cnt;
    logic          exp_ovr;
    logic          prev_all;
    logic [N-1:0]  all_ones;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pat(input logic [W-1:0] base);
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = base + W'(k);
        return d;
    endfunction

    task automatic load_frame(input logic [N*W-1:0] d);
        exp_beats.delete();
`ifdef AXIS_LAYER_CONN_HDR_EN
        exp_beats.push_back({exp_cnt[15:0], 16'(N)});
`endif
        for (int k = 0; k < N; k++) exp_beats.push_back(d[k*W +: W]);
    endtask

    task automatic model_reset();
        exp_beats.delete();
        exp_cnt  = '0;
        exp_ovr  = 1'b0;
        prev_all = 1'b0;
    endtask

    // Predicts the effect of the coming clock edge from the inputs being applied.
    task automatic model_step(input logic [N*W-1:0] d, input logic [N-1:0] dn, input logic rdy);
        bit valid, hsk, fin, rise;
        valid = exp_beats.size() > 0;
        hsk   = valid && rdy;
        fin   = hsk && exp_beats.size() == 1;
        if (hsk) begin
            void'(exp_beats.pop_front());
            if (fin) exp_cnt = exp_cnt + 1;
        end
        rise = (&dn) && !prev_all;
        if (rise) begin
            if (!valid || fin) load_frame(d);
            else exp_ovr = 1'b1;
        end
        prev_all = &dn;
    endtask

    task automatic compare_all();
        bit valid;
        valid = exp_beats.size() > 0;
        check("tvalid", 64'(m_tvalid), 64'(valid));
        check("tlast", 64'(m_tlast), 64'(valid && exp_beats.size() == 1));
        if (valid) check("tdata", 64'(m_tdata), 64'(exp_beats[0]));
        check("busy", 64'(busy), 64'(valid));
        check("overrun", 64'(overrun), 64'(exp_ovr));
        check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt[15:0]));
        check("frame_cnt_w2", 64'(frame_cnt2), 64'(exp_cnt[1:0]));
    endtask

    task automatic drive(input logic [N*W-1:0] d, input logic [N-1:0] dn, input logic rdy);
        ch_data  = d;
        ch_done  = dn;
        m_tready = rdy;
        model_step(d, dn, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
        check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
        check({tag, "_tdata"}, 64'(m_tdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
        check({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
        check({tag, "_cnt_w2"}, 64'(frame_cnt2), 64'd0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(ch_data, '0, 1'b1);
    endtask

    logic [N-1:0] rdone;
    logic [3:0]   tog_pat;

    initial begin
        all_ones = '1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        resetn = 1'b1;

        // Basic frame, full throughput.
        drive(pat(32'h100), all_ones, 1'b1);
        for (int i = 0; i < 24; i++) drive(pat(32'h100), all_ones, 1'b1);
        check("f1_cnt", 64'(frame_cnt), 64'd1);
        drain(3);

        // Ready toggling 1,0,0,1; all_done held high must not retrigger.
        tog_pat = 4'b1001;
        drive(pat(32'h100), all_ones, 1'b1);
        for (int i = 0; i < 90; i++) drive(pat(32'h100), all_ones, tog_pat[i % 4]);
        drain(3);

        // New layer-done coinciding with the final handshake.
        drive(pat(32'h100), all_ones, 1'b1);
        drive(pat(32'h100), '0, 1'b1);
        for (int i = 0; i < 40 && exp_beats.size() != 1; i++) drive(pat(32'h100), '0, 1'b1);
        drive(pat(32'h200), all_ones, 1'b1);
        check("b2b_ovr", 64'(overrun), 64'd0);
        for (int i = 0; i < 24; i++) drive(pat(32'h200), all_ones, 1'b1);
        drain(3);

        // Dropped edge mid-frame sets the sticky overrun flag.
        drive(pat(32'h300), all_ones, 1'b1);
        drive(pat(32'h777), all_ones & ~(N'(1) << 5), 1'b1);
        drive(pat(32'h777), all_ones & ~(N'(1) << 5), 1'b1);
        drive(pat(32'h777), all_ones, 1'b1);
        for (int i = 0; i < 22; i++) drive(pat(32'h777), all_ones, 1'b1);
        drain(3);
        drive(pat(32'h400), all_ones, 1'b1);
        for (int i = 0; i < 24; i++) drive(pat(32'h400), all_ones, 1'b1);
        check("ovr_sticky", 64'(overrun), 64'd1);
        drain(3);

        // Asynchronous reset on beat 7.
        drive(pat(32'h500), all_ones, 1'b1);
        for (int i = 0; i < 7; i++) drive(pat(32'h500), all_ones, 1'b1);
        resetn = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        check_reset_values("inreset");
        resetn = 1'b1;
        drive(pat(32'h600), all_ones, 1'b1);
        for (int i = 0; i < 24; i++) drive(pat(32'h600), all_ones, 1'b1);
        drain(3);

        // Randomized done/ready/data traffic.
        rdone = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                if (rdone == all_ones) rdone = all_ones & ~(N'(1) << $urandom_range(0, N - 1));
                else rdone = all_ones;
            end
            drive(pat(W'($urandom)), rdone, $urandom_range(0, 3) != 0);
        end
        drain(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
